i2s_tx_serializer: RTL

//  I2S transmitter: serializes parallel stereo PCM frames into Philips-format BCK/WS/DATA toward the HDMI TX audio port.

---
 rtl/i2s_tx_serializer_pkg.sv | 37 +++
 rtl/i2s_tx_serializer_if.sv | 29 ++
 rtl/i2s_tx_serializer_bck_gen.sv | 70 +++++++
 rtl/i2s_tx_serializer.sv | 130 +++++++++++++
 4 files changed

// File: rtl/i2s_tx_serializer_pkg.sv
// Package: i2s_tx_serializer_pkg
// Purpose: I2S format constants and default widths shared by the transmit
//          serializer, its bit-clock generator and the receive-side blocks.
// Contents:
//   DEF_*          default sample/slot widths and MCLK-to-BCK divide ratio
//   WS_LEFT/RIGHT  word-select polarity (0 = left channel)
//   MSB_DELAY_BCK  Philips format: MSB follows the WS transition by one BCK
//   load_kind_e    what the shifter receives at a frame boundary
//   wsForBit       word-select level for a given bit position in the frame
package i2s_tx_serializer_pkg;

  localparam int DEF_SAMPLE_WIDTH = 24;
  localparam int DEF_SLOT_WIDTH   = 32;
  localparam int DEF_BCK_HALF_DIV = 2;

  localparam logic WS_LEFT  = 1'b0;
  localparam logic WS_RIGHT = 1'b1;

  localparam int MSB_DELAY_BCK = 1;

  typedef enum logic [1:0] {
    LOAD_NONE,
    LOAD_FRAME,
    LOAD_MUTED,
    LOAD_UNDERRUN
  } load_kind_e;

  // WS switches MSB_DELAY_BCK bits ahead of each slot, so the right-channel
  // window is the slot range shifted earlier by that delay.
  function automatic logic wsForBit(input int bitIdx, input int slotWidth);
    if ((bitIdx >= slotWidth - MSB_DELAY_BCK) &&
        (bitIdx <= 2 * slotWidth - 1 - MSB_DELAY_BCK))
      return WS_RIGHT;
    return WS_LEFT;
  endfunction

endpackage

// File: rtl/i2s_tx_serializer_if.sv
// Interface: i2s_tx_serializer_if
// Purpose: parallel stereo PCM handshake between the sample-rate conversion
//          stage (master) and the I2S transmitter (slave).
// Signals:
//   sample_l_i / sample_r_i  two's-complement sample pair
//   valid_i                  pair is valid
//   ready_o                  transmitter accepts the pair this cycle
//   mute_i                   transmit zeros (pairs are still consumed)
interface i2s_tx_serializer_if #(
  parameter int SAMPLE_WIDTH = 24
);

  logic [SAMPLE_WIDTH-1:0] sample_l_i;
  logic [SAMPLE_WIDTH-1:0] sample_r_i;
  logic                    valid_i;
  logic                    ready_o;
  logic                    mute_i;

  modport master (
    output sample_l_i, sample_r_i, valid_i, mute_i,
    input  ready_o
  );

  modport slave (
    input  sample_l_i, sample_r_i, valid_i, mute_i,
    output ready_o
  );

endinterface

// File: rtl/i2s_tx_serializer_bck_gen.sv
// Module: i2s_bck_gen
// Purpose: derives the I2S bit clock and word select from the audio master
//          clock and tracks the bit position within the stereo frame.
// Ports:
//   i_clk, i_rst   master clock, synchronous active-high reset
//   o_asclk        registered bit clock
//   o_alrclk       registered word select (0 = left)
//   o_fallEvt      high in the cycle whose edge drops the bit clock
//   o_frameLoad    fall event on which the bit counter wraps to 0
module i2s_bck_gen
  import i2s_tx_serializer_pkg::*;
#(
  parameter int SLOT_WIDTH   = DEF_SLOT_WIDTH,
  parameter int BCK_HALF_DIV = DEF_BCK_HALF_DIV
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_asclk,
  output logic o_alrclk,
  output logic o_fallEvt,
  output logic o_frameLoad
);

  localparam int DIV_MAX = 2 * BCK_HALF_DIV - 1;
  localparam int DIV_W   = $clog2(2 * BCK_HALF_DIV);
  localparam int BIT_MAX = 2 * SLOT_WIDTH - 1;
  localparam int BIT_W   = $clog2(2 * SLOT_WIDTH);

  logic [DIV_W-1:0] r_divCnt;
  logic [DIV_W-1:0] w_divNext;
  logic [BIT_W-1:0] r_bitCnt;
  logic [BIT_W-1:0] w_bitNext;
  logic             w_fallEvt;
  logic             r_asclk;
  logic             r_alrclk;

  // Next-state values for the divider and bit counter; the fall event is
  // the last divider count, so the wrap edge is the one that drops BCK.
  always_comb begin
    w_fallEvt = (r_divCnt == DIV_W'(DIV_MAX));
    w_divNext = w_fallEvt ? '0 : r_divCnt + 1'b1;
    w_bitNext = (r_bitCnt == BIT_W'(BIT_MAX)) ? '0 : r_bitCnt + 1'b1;
  end

  // BCK is registered from the next divider count so the output always
  // equals (div_cnt >= BCK_HALF_DIV) with no combinational glitching.
  // The bit counter resets to its last value so the first fall event
  // starts a fresh frame at bit 0.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_divCnt <= '0;
      r_bitCnt <= BIT_W'(BIT_MAX);
      r_asclk  <= 1'b0;
      r_alrclk <= WS_LEFT;
    end else begin
      r_divCnt <= w_divNext;
      r_asclk  <= (w_divNext >= DIV_W'(BCK_HALF_DIV));
      if (w_fallEvt) begin
        r_bitCnt <= w_bitNext;
        r_alrclk <= wsForBit(int'(w_bitNext), SLOT_WIDTH);
      end
    end
  end

  assign o_asclk     = r_asclk;
  assign o_alrclk    = r_alrclk;
  assign o_fallEvt   = w_fallEvt;
  assign o_frameLoad = w_fallEvt && (r_bitCnt == BIT_W'(BIT_MAX));

endmodule

// File: rtl/i2s_tx_serializer.sv
// Module: i2s_tx_serializer
// Purpose: Philips I2S transmitter. Accepts stereo PCM pairs through a
//          valid/ready handshake into a one-deep holding register and
//          shifts them out MSB-first while a second pair can be queued.
// Ports:
//   AMCLK_i, ARST_i  audio master clock, synchronous active-high reset
//   pcm              slave side of the PCM handshake interface
//   ASCLK_o          I2S bit clock (this block is the bit-clock master)
//   ALRCLK_o         I2S word select (0 = left)
//   ASDATA_o         I2S serial data, changes on BCK falling edges
//   frame_start_o    1-cycle strobe when a frame enters the shifter
//   underrun_o       1-cycle strobe when that frame found no queued pair
module i2s_tx_serializer
  import i2s_tx_serializer_pkg::*;
#(
  parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
  parameter int SLOT_WIDTH   = DEF_SLOT_WIDTH,
  parameter int BCK_HALF_DIV = DEF_BCK_HALF_DIV
) (
  input  logic               AMCLK_i,
  input  logic               ARST_i,
  i2s_tx_serializer_if.slave pcm,
  output logic               ASCLK_o,
  output logic               ALRCLK_o,
  output logic               ASDATA_o,
  output logic               frame_start_o,
  output logic               underrun_o
);

  localparam int FRAME_W = 2 * SLOT_WIDTH;
  localparam int PAD_W   = SLOT_WIDTH - SAMPLE_WIDTH;

  logic                    w_fallEvt;
  logic                    w_frameLoad;
  logic                    w_ready;
  logic                    w_xfer;
  load_kind_e              w_loadKind;
  logic [SLOT_WIDTH-1:0]   w_slotL;
  logic [SLOT_WIDTH-1:0]   w_slotR;
  logic [FRAME_W-1:0]      w_shiftNext;
  logic [SAMPLE_WIDTH-1:0] r_holdL;
  logic [SAMPLE_WIDTH-1:0] r_holdR;
  logic                    r_holdFull;
  logic [FRAME_W-1:0]      r_shift;
  logic                    r_asdata;
  logic                    r_frameStart;
  logic                    r_underrun;

  i2s_bck_gen #(
    .SLOT_WIDTH   (SLOT_WIDTH),
    .BCK_HALF_DIV (BCK_HALF_DIV)
  ) u_bckGen (
    .i_clk       (AMCLK_i),
    .i_rst       (ARST_i),
    .o_asclk     (ASCLK_o),
    .o_alrclk    (ALRCLK_o),
    .o_fallEvt   (w_fallEvt),
    .o_frameLoad (w_frameLoad)
  );

  // The holding register frees up in the very cycle it is loaded into the
  // shifter, so a new pair can be taken on that same edge.
  assign w_ready     = !ARST_i && (!r_holdFull || w_frameLoad);
  assign w_xfer      = pcm.valid_i && w_ready;
  assign pcm.ready_o = w_ready;

  // Samples sit left-justified in their slot; the trailing bits are zero.
  assign w_slotL = SLOT_WIDTH'(r_holdL) << PAD_W;
  assign w_slotR = SLOT_WIDTH'(r_holdR) << PAD_W;

  // Decide what the shifter takes at a frame boundary. Mute is looked at
  // only here, so toggling it mid-frame cannot disturb the bits in flight.
  always_comb begin
    w_loadKind = LOAD_NONE;
    if (w_frameLoad) begin
      if (!r_holdFull)
        w_loadKind = LOAD_UNDERRUN;
      else if (pcm.mute_i)
        w_loadKind = LOAD_MUTED;
      else
        w_loadKind = LOAD_FRAME;
    end
  end

  // Shifter next value: a fresh frame at the boundary, otherwise one bit
  // left per BCK. Its MSB is the bit driven on ASDATA_o, which lets the
  // left MSB appear in the same registered update as the load.
  always_comb begin
    w_shiftNext = r_shift;
    case (w_loadKind)
      LOAD_FRAME:    w_shiftNext = {w_slotL, w_slotR};
      LOAD_MUTED:    w_shiftNext = '0;
      LOAD_UNDERRUN: w_shiftNext = '0;
      default:       if (w_fallEvt) w_shiftNext = r_shift << 1;
    endcase
  end

  // Holding register, shifter and strobes. An accept and a load on the
  // same edge leave the holding register full with the new pair while the
  // shifter has already taken the old one from the combinational path.
  always_ff @(posedge AMCLK_i) begin
    if (ARST_i) begin
      r_holdL      <= '0;
      r_holdR      <= '0;
      r_holdFull   <= 1'b0;
      r_shift      <= '0;
      r_asdata     <= 1'b0;
      r_frameStart <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_holdL    <= pcm.sample_l_i;
        r_holdR    <= pcm.sample_r_i;
        r_holdFull <= 1'b1;
      end else if (w_frameLoad) begin
        r_holdFull <= 1'b0;
      end
      r_shift <= w_shiftNext;
      if (w_fallEvt)
        r_asdata <= w_shiftNext[FRAME_W-1];
      r_frameStart <= w_frameLoad;
      r_underrun   <= (w_loadKind == LOAD_UNDERRUN);
    end
  end

  assign ASDATA_o      = r_asdata;
  assign frame_start_o = r_frameStart;
  assign underrun_o    = r_underrun;

endmodule
